// File: rtl/traffic_light_pkg.sv
// Shared types, lamp encodings and phase-length lookup for the traffic light sequencer.
`timescale 1ns/1ps
package traffic_light_pkg;

  // Two-bit encoding leaves 2'b11 spare; the FSM recovers from it to RED.
  typedef enum logic [1:0] {
    S_RED    = 2'b00,
    S_GREEN  = 2'b01,
    S_YELLOW = 2'b10
  } tl_state_t;

  // Lamp vector bit order: [2] red, [1] yellow, [0] green.
  localparam logic [2:0] LIGHT_RED    = 3'b100;
  localparam logic [2:0] LIGHT_YELLOW = 3'b010;
  localparam logic [2:0] LIGHT_GREEN  = 3'b001;

  // Cycle count of the phase held in state s; unencoded states report the RED length.
  function automatic int unsigned phase_len(tl_state_t s,
                                            int unsigned red_len,
                                            int unsigned green_len,
                                            int unsigned yellow_len);
    case (s)
      S_GREEN:  return green_len;
      S_YELLOW: return yellow_len;
      default:  return red_len;
    endcase
  endfunction

endpackage

// File: rtl/traffic_light_fsm.sv
// Self-timed RED -> GREEN -> YELLOW -> RED sequencer with a Moore one-hot lamp output.
//
//   state    | meaning
//   ---------+-------------------------------------------
//   S_RED    | red lamp on for RED_CYCLES clocks
//   S_GREEN  | green lamp on for GREEN_CYCLES clocks
//   S_YELLOW | yellow lamp on for YELLOW_CYCLES clocks
//   (2'b11)  | unencoded; next edge returns to S_RED
`timescale 1ns/1ps
module traffic_light_fsm
  import traffic_light_pkg::*;
#(
  parameter int unsigned RED_CYCLES    = 8,
  parameter int unsigned GREEN_CYCLES  = 8,
  parameter int unsigned YELLOW_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  output logic [2:0] light
);

  localparam int unsigned MAX_RG  = (RED_CYCLES > GREEN_CYCLES) ? RED_CYCLES : GREEN_CYCLES;
  localparam int unsigned MAX_LEN = (MAX_RG > YELLOW_CYCLES) ? MAX_RG : YELLOW_CYCLES;
  localparam int unsigned CNT_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  if (RED_CYCLES < 1) begin : g_bad_red
    $error("RED_CYCLES must be at least 1");
  end
  if (GREEN_CYCLES < 1) begin : g_bad_green
    $error("GREEN_CYCLES must be at least 1");
  end
  if (YELLOW_CYCLES < 1) begin : g_bad_yellow
    $error("YELLOW_CYCLES must be at least 1");
  end

  tl_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] last_cnt;

  // Terminal count for the phase currently being timed.
  always_comb begin
    last_cnt = CNT_W'(phase_len(state_q, RED_CYCLES, GREEN_CYCLES, YELLOW_CYCLES) - 1);
  end

  // State and phase counter registers; reset forces RED with a fresh count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_RED;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, counter update and lamp decode from the registered state only.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    light   = LIGHT_RED;
    case (state_q)
      S_RED: begin
        light = LIGHT_RED;
        if (cnt_q == last_cnt) begin
          state_d = S_GREEN;
          cnt_d   = '0;
        end
      end
      S_GREEN: begin
        light = LIGHT_GREEN;
        if (cnt_q == last_cnt) begin
          state_d = S_YELLOW;
          cnt_d   = '0;
        end
      end
      S_YELLOW: begin
        light = LIGHT_YELLOW;
        if (cnt_q == last_cnt) begin
          state_d = S_RED;
          cnt_d   = '0;
        end
      end
      default: begin
        light   = LIGHT_RED;
        state_d = S_RED;
        cnt_d   = '0;
      end
    endcase
  end

  // Lamp drive must never be dark or show two lamps at once.
  a_light_onehot: assert property (@(posedge clk) $onehot(light))
    else $error("light is not one-hot: %b", light);

endmodule

// File: tb/tb_traffic_light_fsm.sv
// Randomized-reset bench: three differently parameterised sequencers checked against
// an arithmetic model of where each one should be in its repeating period.
`timescale 1ns/1ps
module tb_traffic_light_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] light_a, light_b, light_c;

  int n = 0;
  int chk_cnt = 0;
  int pass_cnt = 0;

  traffic_light_fsm #(.RED_CYCLES(8), .GREEN_CYCLES(8), .YELLOW_CYCLES(2)) u_dut_a (
    .clk(clk), .reset(reset), .light(light_a)
  );
  traffic_light_fsm #(.RED_CYCLES(1), .GREEN_CYCLES(1), .YELLOW_CYCLES(1)) u_dut_b (
    .clk(clk), .reset(reset), .light(light_b)
  );
  traffic_light_fsm #(.RED_CYCLES(3), .GREEN_CYCLES(5), .YELLOW_CYCLES(1)) u_dut_c (
    .clk(clk), .reset(reset), .light(light_c)
  );

  always #5 clk = ~clk;

  // Rising edges seen since reset was last released.
  always @(posedge clk or posedge reset) begin
    if (reset) n <= 0;
    else       n <= n + 1;
  end

  // Lamp expected after k counted edges: position within the R+G+Y period picks the phase.
  function automatic logic [2:0] exp_light(int k, int r, int g, int y);
    int p;
    p = k % (r + g + y);
    if (p < r)          return 3'b100;
    else if (p < r + g) return 3'b001;
    else                return 3'b010;
  endfunction

  task automatic chk(string tag, logic [2:0] got, logic [2:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %b expected %b at t=%0t n=%0d", tag, got, exp, $time, n);
  endtask

  task automatic check_all(string tag);
    chk({tag, "_a"}, light_a, exp_light(n, 8, 8, 2));
    chk({tag, "_b"}, light_b, exp_light(n, 1, 1, 1));
    chk({tag, "_c"}, light_c, exp_light(n, 3, 5, 1));
    chk({tag, "_onehot_a"}, {2'b00, $onehot(light_a)}, 3'b001);
    chk({tag, "_onehot_c"}, {2'b00, $onehot(light_c)}, 3'b001);
  endtask

  initial begin
    reset = 1'b1;
    #1;
    check_all("rst_t0");
    @(posedge clk);
    #2;
    check_all("rst_held_edge");
    #3;
    reset = 1'b0;

    // Five full default periods of free running.
    repeat (90) begin
      @(negedge clk);
      check_all("run");
    end

    // Random run lengths followed by asynchronous reset between edges.
    for (int i = 0; i < 10; i++) begin
      repeat ($urandom_range(3, 40)) begin
        @(negedge clk);
        check_all("run");
      end
      @(posedge clk);
      #($urandom_range(1, 8));
      reset = 1'b1;
      #0.5;
      check_all("async_rst");
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
        check_all("rst_hold");
      end
      @(negedge clk);
      #1;
      reset = 1'b0;
    end

    repeat (40) begin
      @(negedge clk);
      check_all("tail");
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
